// File: rtl/key_event_arbiter.sv
// Purpose     : capture debounced press/release plus long-press per key and round-robin them onto one event port.
// Latency     : key_flag in cycle t -> evt_valid in cycle t+2 when the slot is free and no other key pends.
// Backpressure: slot holds until evt_ready; events wait in per-key pending flags, a hit on a busy flag drops and sets ovf.
// Config      : define KEY_EVT_REPEAT_EN to emit REPEAT events every REPEAT_TICKS ticks after LONG while held.
module key_event_arbiter #(
  parameter int N_KEYS       = 4,
  parameter int TICK_CYCLES  = 50_000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [N_KEYS-1:0]         key_flag,
  input  logic [N_KEYS-1:0]         key_state,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic [1:0]                evt_type,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int KW   = $clog2(N_KEYS);
  // Hold counter is sized for the longer of the two intervals it times.
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);
`endif
  localparam logic [KW-1:0] KEY_LAST  = KW'(N_KEYS - 1);

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_LONG    = 2'b10;
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [1:0] T_REPEAT  = 2'b11;
`endif

  typedef struct packed {
    logic [KW-1:0] key;
    logic [1:0]    typ;
  } evt_t;

  // Timebase
  logic [PW-1:0] presc;
  logic          tick;

  // Per-key state
  logic [N_KEYS-1:0] pend_press, pend_release, pend_long;
  logic [N_KEYS-1:0] set_press, set_release, set_long;
  logic [N_KEYS-1:0] clr_press, clr_release, clr_long;
`ifdef KEY_EVT_REPEAT_EN
  logic [N_KEYS-1:0] pend_repeat, set_repeat, clr_repeat;
`endif
  logic [N_KEYS-1:0] long_done;
  logic [HW-1:0]     hold [N_KEYS];

  // Arbitration
  logic [KW-1:0]     rr_ptr;
  logic [N_KEYS-1:0] pend_any;
  logic [N_KEYS-1:0] pend_rot;
  logic [N_KEYS-1:0] gnt_oh;
  logic              slot_free;
  logic              gnt_found;
  logic              gnt_fire;
  evt_t              gnt;
  logic              ovf_hit;

  assign tick = (presc == PRESC_MAX);

  // Free-running prescaler; tick marks the wrap cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // New event requests: edges from the debouncer, and hold-timer expiries.
  // A key_flag in the same cycle restarts the hold timer, so it suppresses any expiry.
  always_comb begin
    set_press   = key_flag & ~key_state;
    set_release = key_flag & key_state;
    set_long    = '0;
`ifdef KEY_EVT_REPEAT_EN
    set_repeat  = '0;
`endif
    for (int k = 0; k < N_KEYS; k++) begin
      if (tick && !key_flag[k] && !key_state[k]) begin
        if (!long_done[k]) begin
          if (hold[k] == LONG_LAST) set_long[k] = 1'b1;
        end
`ifdef KEY_EVT_REPEAT_EN
        else if (hold[k] == REP_LAST) begin
          set_repeat[k] = 1'b1;
        end
`endif
      end
    end
  end

  // Hold timers: count ticks while pressed; LONG fires once per press, then optionally REPEAT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      long_done <= '0;
      for (int k = 0; k < N_KEYS; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (key_flag[k]) begin
          hold[k]      <= '0;
          long_done[k] <= 1'b0;
        end else if (tick && !key_state[k]) begin
          if (!long_done[k]) begin
            if (set_long[k]) begin
              hold[k]      <= '0;
              long_done[k] <= 1'b1;
            end else begin
              hold[k] <= hold[k] + HW'(1);
            end
          end
`ifdef KEY_EVT_REPEAT_EN
          else begin
            if (set_repeat[k]) hold[k] <= '0;
            else               hold[k] <= hold[k] + HW'(1);
          end
`endif
        end
      end
    end
  end

  assign slot_free = !evt_valid || evt_ready;

`ifdef KEY_EVT_REPEAT_EN
  assign pend_any = pend_press | pend_release | pend_long | pend_repeat;
`else
  assign pend_any = pend_press | pend_release | pend_long;
`endif

  // Round-robin pick: rotate pending keys so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    int off;
    int sum;
    pend_rot  = N_KEYS'({pend_any, pend_any} >> rr_ptr);
    gnt_found = 1'b0;
    off       = 0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        gnt_found = 1'b1;
        off       = i;
      end
    end
    sum = int'(rr_ptr) + off;
    if (sum >= N_KEYS) sum = sum - N_KEYS;
    gnt.key = KW'(sum);
    // Press outranks release so a key's events leave in causal order.
    if (pend_press[gnt.key])        gnt.typ = T_PRESS;
    else if (pend_long[gnt.key])    gnt.typ = T_LONG;
`ifdef KEY_EVT_REPEAT_EN
    else if (pend_repeat[gnt.key])  gnt.typ = T_REPEAT;
`endif
    else                            gnt.typ = T_RELEASE;
  end

  assign gnt_fire = slot_free && gnt_found;

  // Decode the grant into per-type clear masks for the pending flags.
  always_comb begin
    gnt_oh      = gnt_fire ? ({{(N_KEYS-1){1'b0}}, 1'b1} << gnt.key) : '0;
    clr_press   = gnt_oh & {N_KEYS{gnt.typ == T_PRESS}};
    clr_release = gnt_oh & {N_KEYS{gnt.typ == T_RELEASE}};
    clr_long    = gnt_oh & {N_KEYS{gnt.typ == T_LONG}};
`ifdef KEY_EVT_REPEAT_EN
    clr_repeat  = gnt_oh & {N_KEYS{gnt.typ == T_REPEAT}};
`endif
  end

  // Overflow: a request lands on a flag that is still pending and not leaving this cycle.
  always_comb begin
    ovf_hit = |(set_press   & pend_press   & ~clr_press)
            | |(set_release & pend_release & ~clr_release)
            | |(set_long    & pend_long    & ~clr_long);
`ifdef KEY_EVT_REPEAT_EN
    ovf_hit = ovf_hit | |(set_repeat & pend_repeat & ~clr_repeat);
`endif
  end

  // Pending flags: a new request beats a same-cycle grant, so nothing is lost in that case.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_press   <= '0;
      pend_release <= '0;
      pend_long    <= '0;
    end else begin
      pend_press   <= set_press   | (pend_press   & ~clr_press);
      pend_release <= set_release | (pend_release & ~clr_release);
      pend_long    <= set_long    | (pend_long    & ~clr_long);
    end
  end

`ifdef KEY_EVT_REPEAT_EN
  // Repeat flags follow the same set-wins rule as the others.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_repeat <= '0;
    end else begin
      pend_repeat <= set_repeat | (pend_repeat & ~clr_repeat);
    end
  end
`endif

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_hit | (ovf & ~ovf_clr);
    end
  end

  // Output slot and rotate pointer; payload only changes when the slot is free.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= '0;
      rr_ptr    <= '0;
    end else if (slot_free) begin
      evt_valid <= gnt_found;
      if (gnt_found) begin
        evt_key  <= gnt.key;
        evt_type <= gnt.typ;
        rr_ptr   <= (gnt.key == KEY_LAST) ? '0 : gnt.key + KW'(1);
      end
    end
  end

endmodule
